// File: rtl/scroll_pattern_controller.sv
// Pattern buffer owner: loads column bytes, scrolls a read pointer, exposes the rotated window.
// Optional SCROLL_BOUNCE_EN: pointer ping-pongs between 0 and SIZE-1 instead of wrapping.
module scroll_pattern_controller #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     run,
  input  logic                     dir,
  input  logic                     step,
  input  logic [DIV_W-1:0]         rate,
  output logic [WIDTH*SIZE-1:0]    reg_out,
  output logic [$clog2(SIZE)-1:0]  ptr,
  output logic                     busy,
  output logic                     wrap
);

  localparam int PW = $clog2(SIZE);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_LOAD = 1'b1;
  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);

  logic             state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             we, adv;
  logic [WIDTH-1:0] buf_q [SIZE];
`ifdef SCROLL_BOUNCE_EN
  logic             dir_q, dir_d;
`endif

  // Power-up image: a centred peak that scrolls across an otherwise blank display.
  function automatic logic [WIDTH-1:0] init_col(input int i);
    logic [7:0] v;
    case (i)
      4, 11:   v = 8'h10;
      5, 10:   v = 8'h20;
      6, 9:    v = 8'h40;
      7, 8:    v = 8'hFF;
      default: v = 8'h00;
    endcase
    return WIDTH'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    we      = 1'b0;
    adv     = 1'b0;
`ifdef SCROLL_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (state_q == S_LOAD) begin
      if (load_start) begin
        idx_d = '0;
      end else if (wr_valid) begin
        we    = 1'b1;
        idx_d = idx_q + PW'(1);
        if (idx_q == LAST) state_d = S_IDLE;
      end
    end else begin
      if (load_start) begin
        state_d = S_LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef SCROLL_BOUNCE_EN
        dir_d   = 1'b0;
`endif
      end else if (run) begin
        // >= rather than == so a rate lowered below cnt fires on the next cycle
        if (cnt_q >= rate) begin
          cnt_d = '0;
          adv   = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end else begin
        cnt_d = '0;
        adv   = step;
      end
    end
    if (adv) begin
`ifdef SCROLL_BOUNCE_EN
      ptr_d = dir_q ? ptr_q - PW'(1) : ptr_q + PW'(1);
      if ((!dir_q && ptr_d == LAST) || (dir_q && ptr_d == '0)) begin
        wrap_d = 1'b1;
        dir_d  = ~dir_q;
      end
`else
      ptr_d  = dir ? ptr_q - PW'(1) : ptr_q + PW'(1);
      wrap_d = dir ? (ptr_q == '0) : (ptr_q == LAST);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
`ifdef SCROLL_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) buf_q[i] <= init_col(i);
    end else if (we) begin
      buf_q[idx_q] <= wr_data;
    end
  end

  // SIZE is a power of two, so PW-bit addition is the modulo rotation.
  for (genvar g = 0; g < SIZE; g++) begin : g_col
    assign reg_out[WIDTH*g +: WIDTH] = buf_q[ptr_q + PW'(g)];
  end

  assign wr_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign ptr      = ptr_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scroll_pattern_controller.sv
// Directed bench for scroll_pattern_controller with a cycle-level reference model.
module tb_scroll_pattern_controller;

  logic         clk, rst, load_start, wr_valid, wr_ready, run, dir, step, busy, wrap;
  logic [7:0]   wr_data;
  logic [15:0]  rate;
  logic [127:0] reg_out;
  logic [3:0]   ptr;

  int checks = 0;
  int errors = 0;

  scroll_pattern_controller #(.WIDTH(8), .SIZE(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .run(run), .dir(dir), .step(step),
    .rate(rate), .reg_out(reg_out), .ptr(ptr), .busy(busy), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] INIT [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'hFF,
                                       8'hFF, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [127:0] RESET_IMG = 128'h00000000102040FFFF40201000000000;

  // Reference model: plain integers, buffer array and a loading flag.
  logic [7:0] mbuf [16];
  int  mptr, mcnt, midx;
  bit  mload, mwrap, mdir, adv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mbuf[i] = INIT[i];
      mptr = 0; mcnt = 0; midx = 0; mload = 0; mwrap = 0; mdir = 0;
    end else begin
      adv   = 0;
      mwrap = 0;
      if (mload) begin
        if (load_start) midx = 0;
        else if (wr_valid) begin
          mbuf[midx] = wr_data;
          midx++;
          if (midx == 16) mload = 0;
        end
      end else if (load_start) begin
        mload = 1; mptr = 0; mcnt = 0; midx = 0; mdir = 0;
      end else if (run) begin
        if (mcnt >= int'(rate)) begin mcnt = 0; adv = 1; end
        else mcnt++;
      end else begin
        mcnt = 0;
        adv  = step;
      end
      if (adv) begin
`ifdef SCROLL_BOUNCE_EN
        mptr = mdir ? mptr - 1 : mptr + 1;
        if ((!mdir && mptr == 15) || (mdir && mptr == 0)) begin
          mwrap = 1;
          mdir  = !mdir;
        end
`else
        if (dir) begin mwrap = (mptr == 0);  mptr = (mptr + 15) % 16; end
        else     begin mwrap = (mptr == 15); mptr = (mptr + 1) % 16;  end
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [127:0] e;
    for (int i = 0; i < 16; i++) e[8*i +: 8] = mbuf[(mptr + i) % 16];
    chk("reg_out", reg_out, e);
    chk("ptr", 128'(ptr), 128'(mptr));
    chk("busy", 128'(busy), 128'(mload));
    chk("wr_ready", 128'(wr_ready), 128'(mload));
    chk("wrap", 128'(wrap), 128'(mwrap));
  endtask

  // One clock, then compare everything against the model at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  int nw;

  initial begin
    rst = 1; load_start = 0; wr_valid = 0; wr_data = 0; run = 0; dir = 0; step = 0; rate = 0;
    repeat (2) tick();
    chk("rst_img", reg_out, RESET_IMG);
    chk("rst_ptr", 128'(ptr), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_wrap", 128'(wrap), 128'd0);
    rst = 0;
    tick();

    // full load with gaps, then an extra byte that must be refused
    load_start = 1; tick(); load_start = 0;
    chk("load_busy", 128'(busy), 128'd1);
    chk("load_ready", 128'(wr_ready), 128'd1);
    for (int b = 1; b <= 16; b++) begin
      wr_valid = 1; wr_data = 8'(b); tick();
      if (b % 3 == 0) begin wr_valid = 0; tick(); end
    end
    chk("load_done_busy", 128'(busy), 128'd0);
    chk("load_done_ready", 128'(wr_ready), 128'd0);
    wr_valid = 1; wr_data = 8'hEE; tick(); tick(); wr_valid = 0;
    chk("load_img", reg_out, 128'h100F0E0D0C0B0A090807060504030201);

`ifndef SCROLL_BOUNCE_EN
    // automatic scroll, period 4
    rate = 3; dir = 0; run = 1; nw = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (wrap) nw++;
      if (i == 3) chk("scroll_first", 128'(ptr), 128'd1);
    end
    run = 0;
    chk("scroll_wraps", 128'(nw), 128'd1);
    chk("scroll_ptr", 128'(ptr), 128'd0);
    tick();

    // single steps, decrementing wrap, ignored step under run
    dir = 1; step = 1; tick(); step = 0;
    chk("step_dec_ptr", 128'(ptr), 128'd15);
    chk("step_dec_wrap", 128'(wrap), 128'd1);
    tick();
    chk("wrap_one_cycle", 128'(wrap), 128'd0);
    run = 1; rate = 100; step = 1;
    repeat (3) tick();
    chk("step_ignored", 128'(ptr), 128'd15);
    step = 0; rate = 1; tick();
    chk("rate_lowered", 128'(ptr), 128'd14);
    run = 0; dir = 0; step = 1; tick(); tick(); step = 0;
    chk("step_consec", 128'(ptr), 128'd0);
    chk("step_inc_wrap", 128'(wrap), 128'd1);
    tick();
`endif

    // restart a load mid-scroll, restart again inside LOAD, then reset mid-load
    rate = 2; dir = 0; run = 1;
    repeat (7) tick();
    load_start = 1; tick(); load_start = 0;
    chk("reload_ptr", 128'(ptr), 128'd0);
    chk("reload_busy", 128'(busy), 128'd1);
    for (int b = 0; b < 2; b++) begin wr_valid = 1; wr_data = 8'hA0 + 8'(b); tick(); end
    load_start = 1; tick(); load_start = 0;
    for (int b = 0; b < 5; b++) begin wr_valid = 1; wr_data = 8'hB0 + 8'(b); tick(); end
    wr_valid = 0;
    chk("partial_img", reg_out, 128'h100F0E0D0C0B0A09080706B4B3B2B1B0);
    #2 rst = 1;
    #1;
    chk("async_rst_img", reg_out, RESET_IMG);
    chk("async_rst_busy", 128'(busy), 128'd0);
    chk("async_rst_ready", 128'(wr_ready), 128'd0);
    tick();
    run = 0; rst = 0;
    wr_valid = 1; wr_data = 8'h55; tick(); tick(); wr_valid = 0;
    chk("idle_no_write", reg_out, RESET_IMG);

`ifdef SCROLL_BOUNCE_EN
    rate = 0; run = 1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 15) begin
        chk("bounce_top", 128'(ptr), 128'd15);
        chk("bounce_top_wrap", 128'(wrap), 128'd1);
      end
      if (i == 30) begin
        chk("bounce_bot", 128'(ptr), 128'd0);
        chk("bounce_bot_wrap", 128'(wrap), 128'd1);
      end
    end
    chk("bounce_again", 128'(ptr), 128'd1);
    run = 0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_pattern_controller.md
# scroll_pattern_controller

Sequencer and owner of the 16-column, 8-bit display pattern buffer. It loads column bytes from the UART byte stream, rotates a read pointer at a programmable rate or one step at a time, and presents the rotated window as a flat column bus to the display driver. It sits between the UART receiver, the control registers and the column output logic.

## Interface
- WIDTH, 8, bits per column
- SIZE, 16, number of columns; must be a power of two ≥ 2
- DIV_W, 16, prescaler/rate width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse; begin (or restart) pattern load at column 0
- wr_valid  in  1  column byte valid
- wr_data  in  WIDTH  column byte
- wr_ready  out  1  byte accepted when wr_valid & wr_ready
- run  in  1  level; enable automatic scrolling
- dir  in  1  0 = pointer increments, 1 = pointer decrements
- step  in  1  pulse; single advance while run=0
- rate  in  DIV_W  cycles per advance minus 1
- reg_out  out  WIDTH*SIZE  reg_out[WIDTH*i +: WIDTH] = buf[(ptr+i) mod SIZE]
- ptr  out  $clog2(SIZE)  current read pointer
- busy  out  1  high in LOAD
- wrap  out  1  one-cycle pulse when ptr wraps

## Operation
- States: IDLE, LOAD. Reset → IDLE.
- Reset values: buf = {00,00,00,00,10,20,40,FF,FF,40,20,10,00,00,00,00} (hex, index 0..15), ptr=0, prescaler cnt=0, wr_idx=0, wr_ready=0, busy=0, wrap=0.
- IDLE → LOAD on load_start: ptr←0, cnt←0, wr_idx←0.
- LOAD: wr_ready=1, busy=1. Each accepted byte writes buf[wr_idx], wr_idx+1. On the SIZE-th accepted byte → IDLE next cycle; wr_ready drops in that same cycle. load_start in LOAD restarts at wr_idx=0 with no write that cycle. run/step are ignored in LOAD; ptr holds at 0.
- IDLE, run=1: cnt increments each cycle. When cnt ≥ rate: cnt←0 and ptr←ptr±1 mod SIZE (per dir). rate=0 advances every cycle. Lowering rate below cnt advances on the next cycle.
- IDLE, run=0: cnt←0. A step pulse advances ptr one position per dir. step with run=1 is ignored.
- Priority in IDLE: load_start > run advance > step.
- wrap asserts with the ptr update that goes SIZE-1→0 (inc) or 0→SIZE-1 (dec).
- reg_out is combinational from registered buf and ptr. During LOAD it shows partial contents live.

## Timing
- load_start sampled at edge N → busy=1 and wr_ready=1 from N+1.
- Byte accepted at edge N → visible on reg_out after N.
- Advance latency: ptr changes at the edge where cnt ≥ rate. Period = rate+1 cycles.
- step at edge N → ptr updated after N. Consecutive step cycles each advance.
- wrap is registered and high for exactly the cycle ptr holds the wrapped value.
- rst mid-LOAD: immediate return to reset buffer pattern and IDLE. Partial load is discarded.

## Configuration
- SCROLL_BOUNCE_EN defined: ptr ping-pongs between 0 and SIZE-1 under run/step.
  - Internal dir_q (reset 0) replaces dir and reverses in the cycle ptr reaches SIZE-1 (inc) or 0 (dec).
  - wrap pulses at each turnaround instead of at modulo wrap.
  - dir_q←0 on load_start.
  - dir input is ignored.
- SCROLL_BOUNCE_EN undefined: modulo wrap as above. No dir_q register exists.

## Test plan
- Reset → reg_out column 0..15 = 00,00,00,00,10,20,40,FF,FF,40,20,10,00,00,00,00; ptr=0, busy=0, wrap=0.
- load_start, then 16 bytes 0x01..0x10 with wr_valid gaps → busy high throughout, buf[i]=i+1, IDLE after 16th byte, wr_ready=0; a 17th wr_valid is not accepted.
- run=1, rate=3, dir=0 → ptr advances every 4 cycles 0,1,…,15,0; wrap pulses once on 15→0; reg_out column 0 = buf[ptr].
- run=0, dir=1, step pulse at ptr=0 → ptr=15 next cycle with wrap=1; step with run=1 causes no extra advance.
- load_start with run=1 mid-scroll, plus rst asserted after 5 bytes → ptr=0 on load, then reset pattern restored, IDLE, busy=0.
- SCROLL_BOUNCE_EN, rate=0, run=1 → ptr 0,1,…,15,14,…,0,1; wrap pulses at 15 and at 0.
